// File: rtl/risc_spm_control_unit.sv
// Control unit for the RISC_SPM processor.
// A single state register sequences fetch, decode and execute. All strobes
// and mux selects are decoded combinationally from the current state, the
// instruction register contents and the zero flag.
module risc_spm_control_unit (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] instruction,
  input  logic       zero,
  output logic       load_r0,
  output logic       load_r1,
  output logic       load_r2,
  output logic       load_r3,
  output logic       load_pc,
  output logic       inc_pc,
  output logic [2:0] sel_bus_1_mux,
  output logic [1:0] sel_bus_2_mux,
  output logic       load_ir,
  output logic       load_add_r,
  output logic       load_reg_y,
  output logic       load_reg_z,
  output logic       write,
  output logic       halted
);

  typedef enum logic [3:0] {
    S_IDLE, S_FET1, S_FET2, S_DEC, S_EX1, S_RD1, S_RD2,
    S_WR1, S_WR2, S_BR1, S_BR2, S_HALT
  } state_t;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_NOT = 4'd4;
  localparam logic [3:0] OP_RD  = 4'd5;
  localparam logic [3:0] OP_WR  = 4'd6;
  localparam logic [3:0] OP_BR  = 4'd7;
  localparam logic [3:0] OP_BRZ = 4'd8;

  localparam logic [2:0] SEL1_PC   = 3'd4;
  localparam logic [1:0] SEL2_ALU  = 2'd0;
  localparam logic [1:0] SEL2_BUS1 = 2'd1;
  localparam logic [1:0] SEL2_MEM  = 2'd2;

  state_t     state;
  state_t     next;
  logic [3:0] opcode;
  logic [1:0] src;
  logic [1:0] dest;
  logic [3:0] load_r;

  assign opcode  = instruction[7:4];
  assign src     = instruction[3:2];
  assign dest    = instruction[1:0];
  assign load_r0 = load_r[0];
  assign load_r1 = load_r[1];
  assign load_r2 = load_r[2];
  assign load_r3 = load_r[3];

  // State register; reset forces S_IDLE immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next;
  end

  // Next-state and output decode; every output defaults to 0.
  always_comb begin
    next          = state;
    load_r        = 4'b0000;
    load_pc       = 1'b0;
    inc_pc        = 1'b0;
    sel_bus_1_mux = 3'd0;
    sel_bus_2_mux = SEL2_ALU;
    load_ir       = 1'b0;
    load_add_r    = 1'b0;
    load_reg_y    = 1'b0;
    load_reg_z    = 1'b0;
    write         = 1'b0;
    halted        = 1'b0;
    case (state)
      S_IDLE: next = S_FET1;
      S_FET1: begin
        sel_bus_1_mux = SEL1_PC;
        sel_bus_2_mux = SEL2_BUS1;
        load_add_r    = 1'b1;
        next          = S_FET2;
      end
      S_FET2: begin
        sel_bus_2_mux = SEL2_MEM;
        load_ir       = 1'b1;
        inc_pc        = 1'b1;
        next          = S_DEC;
      end
      S_DEC: begin
        case (opcode)
          OP_NOP: next = S_FET1;
          OP_ADD, OP_SUB, OP_AND: begin
            sel_bus_1_mux = {1'b0, src};
            sel_bus_2_mux = SEL2_BUS1;
            load_reg_y    = 1'b1;
            next          = S_EX1;
          end
          OP_NOT: begin
            sel_bus_1_mux = {1'b0, src};
            sel_bus_2_mux = SEL2_ALU;
            load_reg_z    = 1'b1;
            load_r        = 4'b0001 << dest;
            next          = S_FET1;
          end
          OP_RD, OP_WR, OP_BR: begin
            sel_bus_1_mux = SEL1_PC;
            sel_bus_2_mux = SEL2_BUS1;
            load_add_r    = 1'b1;
            if (opcode == OP_RD)      next = S_RD1;
            else if (opcode == OP_WR) next = S_WR1;
            else                      next = S_BR1;
          end
          OP_BRZ: begin
            if (zero) begin
              sel_bus_1_mux = SEL1_PC;
              sel_bus_2_mux = SEL2_BUS1;
              load_add_r    = 1'b1;
              next          = S_BR1;
            end else begin
              // Not taken: step the PC past the branch address byte.
              inc_pc = 1'b1;
              next   = S_FET1;
            end
          end
          default: next = S_HALT;
        endcase
      end
      S_EX1: begin
        sel_bus_1_mux = {1'b0, dest};
        sel_bus_2_mux = SEL2_ALU;
        load_reg_z    = 1'b1;
        load_r        = 4'b0001 << dest;
        next          = S_FET1;
      end
      S_RD1, S_WR1: begin
        sel_bus_2_mux = SEL2_MEM;
        load_add_r    = 1'b1;
        inc_pc        = 1'b1;
        next          = (state == S_RD1) ? S_RD2 : S_WR2;
      end
      S_RD2: begin
        sel_bus_2_mux = SEL2_MEM;
        load_r        = 4'b0001 << dest;
        next          = S_FET1;
      end
      S_WR2: begin
        sel_bus_1_mux = {1'b0, src};
        write         = 1'b1;
        next          = S_FET1;
      end
      S_BR1: begin
        sel_bus_2_mux = SEL2_MEM;
        load_add_r    = 1'b1;
        next          = S_BR2;
      end
      S_BR2: begin
        sel_bus_2_mux = SEL2_MEM;
        load_pc       = 1'b1;
        next          = S_FET1;
      end
      S_HALT: begin
        halted = 1'b1;
        next   = S_HALT;
      end
      default: next = S_IDLE;
    endcase
  end

endmodule

// File: doc/risc_spm_control_unit.md
RISC_SPM_CONTROL_UNIT -- requirements
Module: risc_spm_control_unit

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-high; ports clk and rst.
REQ-003 clk  input  1  processor clock; all state changes on posedge.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 instruction  input  8  IR contents; [7:4] opcode, [3:2] src, [1:0] dest.
REQ-006 zero  input  1  Reg_Z flag from the processing unit.
REQ-007 load_r0, load_r1, load_r2, load_r3  output  1 each  register load strobes.
REQ-008 load_pc, inc_pc  output  1 each  PC load and PC increment.
REQ-009 sel_bus_1_mux  output  3  Bus_1 source: 0=R0, 1=R1, 2=R2, 3=R3, 4=PC.
REQ-010 sel_bus_2_mux  output  2  Bus_2 source: 0=ALU, 1=Bus_1, 2=mem_word.
REQ-011 load_ir, load_add_r, load_reg_y, load_reg_z  output  1 each  register load strobes.
REQ-012 write  output  1  memory write strobe.
REQ-013 halted  output  1  high while the FSM is in S_HALT.

Function
REQ-014 The FSM SHALL have the states S_IDLE, S_FET1, S_FET2, S_DEC, S_EX1, S_RD1, S_RD2, S_WR1, S_WR2, S_BR1, S_BR2 and S_HALT; the state register is the only storage.
REQ-015 Outputs SHALL be combinational from the current state, instruction and zero; any output not listed for a state SHALL be 0.
REQ-016 Opcodes SHALL be: NOP=0, ADD=1, SUB=2, AND=3, NOT=4, RD=5, WR=6, BR=7, BRZ=8; opcodes 9-15 are illegal.
REQ-017 S_IDLE SHALL drive all outputs to 0 and go to S_FET1.
REQ-018 S_FET1 SHALL drive sel1=PC, sel2=Bus_1 and load_add_r, then go to S_FET2.
REQ-019 S_FET2 SHALL drive sel2=mem, load_ir and inc_pc, then go to S_DEC.
REQ-020 S_DEC SHALL handle the opcode as follows:
- NOP: go to S_FET1.
- ADD/SUB/AND: sel1=src, sel2=Bus_1, load_reg_y; go to S_EX1.
- NOT: sel1=src, sel2=ALU, load_reg_z, load_r[dest]; go to S_FET1.
- RD/WR/BR: sel1=PC, sel2=Bus_1, load_add_r; go to S_RD1, S_WR1 or S_BR1 respectively.
- BRZ with zero=1: same as BR, go to S_BR1.
- BRZ with zero=0: inc_pc only (skips the address byte); go to S_FET1.
- Illegal opcode: go to S_HALT.
REQ-021 S_EX1 SHALL drive sel1=dest, sel2=ALU, load_reg_z and load_r[dest], then go to S_FET1.
REQ-022 S_RD1 SHALL drive sel2=mem, load_add_r and inc_pc, then go to S_RD2.
REQ-023 S_RD2 SHALL drive sel2=mem and load_r[dest], then go to S_FET1.
REQ-024 S_WR1 SHALL drive sel2=mem, load_add_r and inc_pc, then go to S_WR2.
REQ-025 S_WR2 SHALL drive sel1=src and write, then go to S_FET1.
REQ-026 S_BR1 SHALL drive sel2=mem and load_add_r, then go to S_BR2.
REQ-027 S_BR2 SHALL drive sel2=mem and load_pc, then go to S_FET1.
REQ-028 S_HALT SHALL drive halted=1 with all other outputs 0, and SHALL remain there until rst.
REQ-029 At most one of load_r0..load_r3 SHALL be high in any cycle.
REQ-030 load_pc and inc_pc SHALL never be high together.
REQ-031 Instruction latency in clocks SHALL be: NOP=3, NOT=3, BRZ not taken=3, ADD/SUB/AND=4, RD/WR/BR/BRZ taken=5.

Reset
REQ-032 rst=1 SHALL force S_IDLE immediately and asynchronously; all outputs, including halted, are 0 while rst is high.
REQ-033 rst asserted mid-instruction (e.g. in S_WR2) SHALL drop write in the same cycle; no partial completion occurs after reset.
REQ-034 After rst deasserts, the first posedge SHALL go S_IDLE->S_FET1.

Verification
REQ-035 Reset, then instruction=8'h00 (NOP) -> states IDLE,FET1,FET2,DEC,FET1; load_add_r in FET1; load_ir and inc_pc in FET2.
REQ-036 instruction=8'h16 (ADD src=R1, dest=R2) -> DEC: sel1=1, load_reg_y; EX1: sel1=2, sel2=0, load_r2, load_reg_z; 4 clocks total.
REQ-037 instruction=8'h80 (BRZ) with zero=0 -> DEC: inc_pc only, then FET1; with zero=1 -> BR1 then BR2 with load_pc=1, sel2=2.
REQ-038 instruction=8'h64 (WR src=R1) -> WR2: sel1=1, write=1 for exactly one clock; rst pulsed during WR2 -> write=0 and state S_IDLE asynchronously.
REQ-039 instruction=8'hF0 -> DEC then HALT; halted=1 is held for more than 10 clocks regardless of instruction; rst returns halted to 0.
REQ-040 A random legal instruction stream SHALL be checked every cycle against REQ-029 and REQ-030 by assertions.
